// File: rtl/ifid_stage_pkg.sv
// Shared MIPS opcodes and IF/ID stage FSM encodings.
// Used by hazard detection and by the forwarding logic.
package ifid_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  localparam logic [63:0] IFID_NOP = 64'h0;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) ||
           (op == OP_LBU);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) ||
           (op == OP_SB) || (op == OP_BEQ) ||
           (op == OP_BNE);
  endfunction

endpackage

// File: rtl/ifid_stage_load_use_detect.sv
// Load-use hazard detect between ID/EX load and IF/ID consumer.
// Purely combinational; rt of zero never creates a hazard.
import ifid_stage_pkg::*;

module load_use_detect (
  input  logic [31:0]  ifid_instr,
  input  logic [159:0] idex_reg,
  output logic         load_use
);

  logic [5:0] ex_op;
  logic [4:0] ex_rt;
  logic [5:0] id_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_bits;

  assign ex_op = idex_reg[31:26];
  assign ex_rt = idex_reg[20:16];
  assign id_op = ifid_instr[31:26];
  assign id_rs = ifid_instr[25:21];
  assign id_rt = ifid_instr[20:16];

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = (ex_rt == id_rt) && uses_rt(id_op);

  assign load_use = is_load(ex_op) &&
                    (ex_rt != 5'd0) &&
                    (rs_hit || rt_hit);

  assign unused_bits = ^{idex_reg[159:32],
                         idex_reg[25:21],
                         idex_reg[15:0],
                         ifid_instr[15:0]};

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with load-use stall, fetch-miss
// and flush handling, plus a saturating stall counter.
import ifid_stage_pkg::*;

module ifid_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc4,
  input  logic                   imem_ready,
  input  logic [159:0]           idex_reg,
  input  logic                   flush,
  output logic [63:0]            ifid_reg,
  output logic                   pc_write,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [63:0] ifid_nxt;
  logic        pcw_c;
  logic        bub_c;
  logic        lu;
  logic        lu_eff;
  logic        do_flush;
  logic        do_hold;
  logic        do_miss;
  logic        do_load;

  load_use_detect u_lud (
    .ifid_instr (ifid_reg[31:0]),
    .idex_reg   (idex_reg),
    .load_use   (lu)
  );

  // HOLD and MISS ignore load-use so a stall lasts one cycle.
  assign lu_eff   = lu && (state == ST_RUN);
  assign do_flush = flush;
  assign do_hold  = !flush && lu_eff;
  assign do_miss  = !flush && !lu_eff && !imem_ready;
  assign do_load  = !flush && !lu_eff && imem_ready;

  // Next-state and register-load decode.
  always_comb begin
    state_nxt = ST_RUN;
    ifid_nxt  = ifid_reg;
    pcw_c     = 1'b0;
    bub_c     = 1'b0;
    unique case (1'b1)
      do_flush: begin
        ifid_nxt = IFID_NOP;
        pcw_c    = 1'b1;
      end
      do_hold: begin
        bub_c     = 1'b1;
        state_nxt = ST_HOLD;
      end
      do_miss: begin
        ifid_nxt  = IFID_NOP;
        state_nxt = ST_MISS;
      end
      do_load: begin
        ifid_nxt = {if_pc4, if_instr};
        pcw_c    = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign pc_write    = pcw_c && rst_n;
  assign idex_bubble = bub_c && rst_n;

  // State, IF/ID register and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ifid_reg  <= IFID_NOP;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ifid_reg <= ifid_nxt;
      if (!pcw_c && !(&stall_cnt))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifid_stage.sv
// Directed test of the IF/ID stage.
// Hand-computed vectors, immediate assertions.
module tb_ifid_stage;

  logic         clk;
  logic         rst_n;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc4;
  logic         imem_ready;
  logic [159:0] idex_reg;
  logic         flush;
  logic [63:0]  ifid;
  logic         pcw;
  logic         bub;
  logic [15:0]  cnt;
  logic [63:0]  ifid2;
  logic         pcw2;
  logic         bub2;
  logic [1:0]   cnt2;

  int vectors = 0;
  int errs    = 0;

  localparam logic [31:0] LW_T0  = 32'h8E08_0000;
  localparam logic [31:0] LW_R0  = 32'h8E00_0000;
  localparam logic [31:0] ADD_T0 = 32'h010A_4820;
  localparam logic [31:0] ADD_Z  = 32'h000A_4820;
  localparam logic [31:0] SW_T0  = 32'hAE28_0000;
  localparam logic [31:0] ADDI   = 32'h2228_0005;
  localparam logic [31:0] LUI    = 32'h3C01_1234;

  ifid_stage #(.STALL_CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .imem_ready  (imem_ready),
    .idex_reg    (idex_reg),
    .flush       (flush),
    .ifid_reg    (ifid),
    .pc_write    (pcw),
    .idex_bubble (bub),
    .stall_cnt   (cnt)
  );

  ifid_stage #(.STALL_CNT_W(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .imem_ready  (imem_ready),
    .idex_reg    (idex_reg),
    .flush       (flush),
    .ifid_reg    (ifid2),
    .pc_write    (pcw2),
    .idex_bubble (bub2),
    .stall_cnt   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] w);
    idex_reg = {128'h0, w};
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    imem_ready = 1'b1;
    if_instr   = ADD_T0;
    if_pc4     = 32'h0000_0008;
    set_ex(32'h0);
    #2;
    chk("rst_ifid", ifid, 64'h0);
    chk("rst_pcw", {63'h0, pcw}, 64'h0);
    chk("rst_bub", {63'h0, bub}, 64'h0);
    chk("rst_cnt", {48'h0, cnt}, 64'h0);
    #1 rst_n = 1'b1;
    #1;
    chk("run_pcw", {63'h0, pcw}, 64'h1);
    tick();
    chk("load_add", ifid, {32'h8, ADD_T0});

    // load-use: lw $t0 then add using $t0 as rs
    set_ex(LW_T0);
    if_instr = LUI;
    if_pc4   = 32'h0000_000C;
    #1;
    chk("lu_pcw", {63'h0, pcw}, 64'h0);
    chk("lu_bub", {63'h0, bub}, 64'h1);
    tick();
    chk("lu_hold", ifid, {32'h8, ADD_T0});
    chk("lu_cnt", {48'h0, cnt}, 64'd1);
    chk("hold_pcw", {63'h0, pcw}, 64'h1);
    chk("hold_bub", {63'h0, bub}, 64'h0);
    tick();
    chk("hold_load", ifid, {32'hC, LUI});
    chk("hold_cnt", {48'h0, cnt}, 64'd1);

    // lw with rt=0 never stalls
    set_ex(32'h0);
    if_instr = ADD_Z;
    if_pc4   = 32'h0000_0010;
    tick();
    set_ex(LW_R0);
    if_pc4 = 32'h0000_0014;
    #1;
    chk("r0_pcw", {63'h0, pcw}, 64'h1);
    chk("r0_bub", {63'h0, bub}, 64'h0);
    tick();
    chk("r0_load", ifid, {32'h14, ADD_Z});

    // store reading rt hazards; flush wins over it
    set_ex(32'h0);
    if_instr = SW_T0;
    if_pc4   = 32'h0000_0018;
    tick();
    set_ex(LW_T0);
    if_instr = LUI;
    if_pc4   = 32'h0000_001C;
    #1;
    chk("sw_bub", {63'h0, bub}, 64'h1);
    flush = 1'b1;
    #1;
    chk("fl_bub", {63'h0, bub}, 64'h0);
    chk("fl_pcw", {63'h0, pcw}, 64'h1);
    tick();
    flush = 1'b0;
    chk("fl_ifid", ifid, 64'h0);
    chk("fl_cnt", {48'h0, cnt}, 64'd1);

    // addi writes rt, so rt match is not a hazard
    set_ex(32'h0);
    if_instr = ADDI;
    if_pc4   = 32'h0000_0020;
    tick();
    set_ex(LW_T0);
    if_instr = LUI;
    if_pc4   = 32'h0000_0024;
    #1;
    chk("addi_bub", {63'h0, bub}, 64'h0);
    chk("addi_pcw", {63'h0, pcw}, 64'h1);
    tick();
    chk("addi_next", ifid, {32'h24, LUI});

    // three fetch misses then a hit
    set_ex(32'h0);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_pcw", {63'h0, pcw}, 64'h0);
      tick();
      chk("miss_nop", ifid, 64'h0);
    end
    imem_ready = 1'b1;
    if_instr   = 32'h2008_0005;
    if_pc4     = 32'h0000_0104;
    #1;
    chk("hit_pcw", {63'h0, pcw}, 64'h1);
    tick();
    chk("hit_load", ifid, 64'h0000_0104_2008_0005);
    chk("miss_cnt", {48'h0, cnt}, 64'd4);
    chk("sat_cnt2", {62'h0, cnt2}, 64'd3);

    // async reset pulse while in MISS
    imem_ready = 1'b0;
    tick();
    chk("pre_rst_cnt", {48'h0, cnt}, 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cnt", {48'h0, cnt}, 64'h0);
    chk("arst_cnt2", {62'h0, cnt2}, 64'h0);
    chk("arst_ifid", ifid, 64'h0);
    chk("arst_pcw", {63'h0, pcw}, 64'h0);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_pcw", {63'h0, pcw}, 64'h0);

    // narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2)
        chk("cnt2_at3", {62'h0, cnt2}, 64'd3);
    end
    chk("cnt2_hold", {62'h0, cnt2}, 64'd3);
    chk("cnt_wide", {48'h0, cnt}, 64'd5);
    imem_ready = 1'b1;
    if_instr   = LUI;
    if_pc4     = 32'h0000_0200;
    tick();
    chk("final_load", ifid, {32'h200, LUI});
    chk("final_cnt", {48'h0, cnt}, 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
